fetch_unit: RTL and testbench

Instruction-fetch and PC-sequencing stage of the 16-bit, 3-bit-opcode processor. It holds the PC and fetches from instruction memory over a valid/request handshake. It presents the latched instruction and its opcode to the main control decoder, then consumes the decoder's Jump/Branch outputs plus the ALU zero flag to choose the next PC. It also exports PC+1 for the jal link-write path (MemtoReg=2'b10, RegDst=2'b10).

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch and PC-sequencing stage: fetches over a req/valid handshake,
// holds the instruction for execute and selects the next PC from jump/branch/zero.
module fetch_unit #(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic               instr_valid,
    input  logic               jump,
    input  logic               branch,
    input  logic               alu_zero,
    input  logic               stall,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus1,
    output logic [15:0]        retired_cnt
);

    typedef enum logic [1:0] {
        SFetchIdle,
        SFetch,
        SExec
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [15:0]        retired_q, retired_d;
    logic [PC_W-1:0]    imm_sext;
    logic [PC_W-1:0]    next_pc;

    assign pc_plus1 = pc_q + PC_W'(1);
    assign imm_sext = {{(PC_W-7){instr_q[6]}}, instr_q[6:0]};

    // Jump keeps the region bits of pc_plus1; jump wins over branch.
    always_comb begin
        next_pc = pc_plus1;
        if (jump) begin
            next_pc = {pc_plus1[PC_W-1:13], instr_q[12:0]};
        end else if (branch && alu_zero) begin
            next_pc = pc_plus1 + imm_sext;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            SFetchIdle: begin
                state_d = SFetch;
            end
            SFetch: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = SExec;
                end
            end
            SExec: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 16'd1;
                    state_d   = SFetch;
                end
            end
            default: begin
                state_d = SFetchIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= SFetchIdle;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[INSTR_W-1 -: 3];
    assign pc          = pc_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, opcode decoder model and a
// scoreboard of expected fetch addresses popped on each new fetch request.
module tb_fetch_unit;

    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_JAL = 3'b111;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic        instr_valid;
    logic        jump;
    logic        branch;
    logic        alu_zero;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic [15:0] retired_cnt;

    logic [15:0] mem [0:65535];
    logic        force_en;
    logic [15:0] force_val;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pops = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_addr;
    logic        req_prev = 1'b0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .jump        (jump),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .stall       (stall),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = force_en ? force_val : mem[imem_addr];
    assign jump       = instr_valid && (opcode == OP_JAL);
    assign branch     = instr_valid && (opcode == OP_BEQ);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_beq(input logic [6:0] imm);
        return {OP_BEQ, 6'b0, imm};
    endfunction

    function automatic logic [15:0] enc_jal(input logic [12:0] tgt);
        return {OP_JAL, tgt};
    endfunction

    // Each rising request while out of reset starts a new fetch.
    always @(negedge clk) begin
        if (rst && imem_req && !req_prev) begin
            if (sb.size() == 0) begin
                check_eq("sb_has_entry", sb.size(), 1);
            end else begin
                exp_addr = sb.pop_front();
                check_eq("fetch_addr", imem_addr, exp_addr);
            end
            pops++;
        end
        req_prev = rst && imem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pops(input int n);
        int target;
        target = pops + n;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (pops >= target) break;
        end
        check_eq("run_pops", pops, target);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10; i++) begin
            if (instr_valid) break;
            tick();
        end
        check_eq("exec_reached", instr_valid, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        check_eq("sb_drained", sb.size(), 0);
        rst = 1'b0;
        sb.delete();
        tick();
        tick();
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_pc", pc, 16'h0000);
        check_eq("rst_instr", instr, 16'h0000);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_retired", retired_cnt, 0);
        rst = 1'b1;
        check_eq("idle_req", imem_req, 0);
    endtask

    initial begin
        int vcnt;
        rst        = 1'b0;
        imem_valid = 1'b1;
        alu_zero   = 1'b0;
        stall      = 1'b0;
        force_en   = 1'b0;
        force_val  = 16'h0000;
        foreach (mem[i]) mem[i] = 16'h0000;

        // Sequential non-branch stream, valid always high.
        do_reset();
        sb.push_back(16'h0000);
        sb.push_back(16'h0001);
        sb.push_back(16'h0002);
        sb.push_back(16'h0003);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("seq_req", imem_req, (i % 2 == 0) ? 1 : 0);
        end
        tick();
        check_eq("seq_retired", retired_cnt, 3);
        check_eq("seq_addr3", imem_addr, 16'h0003);

        // beq taken backwards then not taken.
        mem[16'h0000] = enc_jal(13'h0010);
        mem[16'h0010] = enc_beq(7'h7E);
        mem[16'h000F] = enc_jal(13'h0010);
        alu_zero = 1'b1;
        do_reset();
        sb.push_back(16'h0000);
        sb.push_back(16'h0010);
        sb.push_back(16'h000F);
        run_pops(3);
        alu_zero = 1'b0;
        sb.push_back(16'h0010);
        sb.push_back(16'h0011);
        run_pops(2);

        // Climb into the 0x2000 region, then jal keeps upper pc_plus1 bits.
        mem[16'h0000] = enc_jal(13'h1FC0);
        mem[16'h1FC0] = enc_beq(7'h3F);
        mem[16'h2000] = enc_jal(13'h0005);
        mem[16'h2005] = enc_jal(13'h0123);
        alu_zero = 1'b1;
        do_reset();
        sb.push_back(16'h0000);
        sb.push_back(16'h1FC0);
        sb.push_back(16'h2000);
        sb.push_back(16'h2005);
        sb.push_back(16'h2123);
        run_pops(4);
        wait_valid();
        check_eq("jal_pc", pc, 16'h2005);
        check_eq("jal_pc_plus1", pc_plus1, 16'h2006);
        run_pops(1);

        // Delayed response, ignored valid in execute, stall.
        mem[16'h0000] = 16'h0ABC;
        mem[16'h0001] = 16'h1234;
        imem_valid = 1'b0;
        alu_zero   = 1'b0;
        do_reset();
        sb.push_back(16'h0000);
        sb.push_back(16'h0001);
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("wait_req", imem_req, 1);
            check_eq("wait_addr", imem_addr, 16'h0000);
            check_eq("wait_instr", instr, 16'h0000);
            if (i == 2) imem_valid = 1'b1;
            tick();
        end
        check_eq("accept_instr", instr, 16'h0ABC);
        vcnt = instr_valid ? 1 : 0;
        force_en  = 1'b1;
        force_val = 16'hFFFF;
        stall     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (instr_valid) vcnt++;
            check_eq("stall_pc", pc, 16'h0000);
            check_eq("stall_retired", retired_cnt, 0);
            check_eq("stall_instr", instr, 16'h0ABC);
        end
        check_eq("stall_valid_cycles", vcnt, 5);
        stall    = 1'b0;
        force_en = 1'b0;
        tick();
        check_eq("post_stall_valid", instr_valid, 0);
        check_eq("post_stall_retired", retired_cnt, 1);

        // Wrap below zero and past 0xFFFF, then reset mid-fetch.
        mem[16'h0000] = enc_beq(7'h7E);
        mem[16'hFFFF] = 16'h0000;
        alu_zero = 1'b1;
        do_reset();
        sb.push_back(16'h0000);
        sb.push_back(16'hFFFF);
        sb.push_back(16'h0000);
        sb.push_back(16'hFFFF);
        run_pops(2);
        wait_valid();
        check_eq("wrap_pc", pc, 16'hFFFF);
        check_eq("wrap_pc_plus1", pc_plus1, 16'h0000);
        run_pops(2);
        check_eq("pre_rst_retired", retired_cnt, 3);
        check_eq("pre_rst_req", imem_req, 1);
        rst = 1'b0;
        tick();
        check_eq("midrst_req", imem_req, 0);
        check_eq("midrst_pc", pc, 16'h0000);
        check_eq("midrst_valid", instr_valid, 0);
        check_eq("midrst_instr", instr, 16'h0000);
        check_eq("midrst_retired", retired_cnt, 0);
        check_eq("sb_final", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
